apb_fifo_ctrl: RTL

//  APB3 slave sequencer in front of the I2S transceiver Tx/Rx FIFOs.

---
 rtl/i2s_pkg.sv | 21 ++
 rtl/wait_timer.sv | 42 ++++
 rtl/apb_fifo_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2s_pkg: shared state encoding and register map for the I2S APB front end.
// Rev 1.0
// ---------------------------------------------------------------------------
package i2s_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TX_PUSH = 3'd1,
    RX_POP  = 3'd2,
    RX_CAPT = 3'd3,
    DONE    = 3'd4
  } apb_state_t;

  localparam logic [31:0] ADDR_CTRL = 32'h0000_0000;
  localparam logic [31:0] ADDR_TX   = 32'h0000_0004;
  localparam logic [31:0] ADDR_RX   = 32'h0000_0008;

endpackage
`default_nettype wire

// File: rtl/wait_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wait_timer: saturating wait-state counter; expired once WAIT_MAX is reached.
// Rev 1.0
// ---------------------------------------------------------------------------
module wait_timer #(
  parameter int WAIT_MAX = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(WAIT_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // WAIT_MAX of zero disables the timeout altogether.
  assign expired_o = (WAIT_MAX != 0) && (cnt_q == CNT_SAT);

endmodule
`default_nettype wire

// File: rtl/apb_fifo_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_fifo_ctrl: APB3 slave sequencing CTRL/TX/RX accesses onto the I2S FIFOs.
// Rev 1.0
// ---------------------------------------------------------------------------
module apb_fifo_ctrl
  import i2s_pkg::*;
#(
  parameter int WAIT_MAX = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic [3:0]  flags,
  output logic [31:0] controls,
  output logic [31:0] Tx_data,
  output logic        Tx_wen,
  input  logic        Tx_full,
  input  logic [31:0] Rx_data,
  output logic        Rx_ren,
  input  logic        Rx_empty
);

  apb_state_t  state_q, state_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] controls_q, controls_d;
  logic [31:0] prdata_q, prdata_d;
  logic [31:0] txhold_q, txhold_d;
  logic        err_q, err_d;
  logic        pready_q;
  logic        tx_wen, rx_ren;
  logic        tmr_clr, tmr_en, tmr_expired;

  wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .pclk      (pclk),
    .preset    (preset),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    wdata_d    = wdata_q;
    controls_d = controls_q;
    prdata_d   = prdata_q;
    err_d      = err_q;
    tx_wen     = 1'b0;
    rx_ren     = 1'b0;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;

    // A dropped psel aborts any transfer in flight before a strobe can fire.
    if ((state_q != IDLE) && !psel) begin
      state_d = IDLE;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            wdata_d = pwdata;
            tmr_clr = 1'b1;
            err_d   = 1'b0;
            if (paddr == ADDR_CTRL) begin
              state_d = DONE;
              if (pwrite) controls_d = pwdata;
              else        prdata_d   = {flags, controls_q[27:0]};
            end else if ((paddr == ADDR_TX) && pwrite) begin
              state_d = TX_PUSH;
            end else if ((paddr == ADDR_RX) && !pwrite) begin
              state_d = RX_POP;
            end else begin
              err_d   = 1'b1;
              state_d = DONE;
            end
          end
        end
        TX_PUSH: begin
          if (!Tx_full) begin
            tx_wen  = 1'b1;
            state_d = DONE;
          end else if (tmr_expired) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            tmr_en = 1'b1;
          end
        end
        RX_POP: begin
          if (!Rx_empty) begin
            rx_ren  = 1'b1;
            state_d = RX_CAPT;
          end else if (tmr_expired) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            tmr_en = 1'b1;
          end
        end
        RX_CAPT: begin
          prdata_d = Rx_data;
          state_d  = DONE;
        end
        DONE: begin
          if (penable) begin
            state_d = IDLE;
            err_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      endcase
    end
  end

  // Tx_data shows the pending word only while strobing, else the last pushed word.
  always_comb begin
    txhold_d = txhold_q;
    if (tx_wen) txhold_d = wdata_q;
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q    <= IDLE;
      wdata_q    <= '0;
      controls_q <= '0;
      prdata_q   <= '0;
      txhold_q   <= '0;
      err_q      <= 1'b0;
      pready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wdata_q    <= wdata_d;
      controls_q <= controls_d;
      prdata_q   <= prdata_d;
      txhold_q   <= txhold_d;
      err_q      <= err_d;
      pready_q   <= (state_d == DONE);
    end
  end

  assign prdata   = prdata_q;
  assign pready   = pready_q;
  assign pslverr  = err_q;
  assign controls = controls_q;
  assign Tx_data  = tx_wen ? wdata_q : txhold_q;
  assign Tx_wen   = tx_wen;
  assign Rx_ren   = rx_ren;

endmodule
`default_nettype wire
